axi_wr_arbiter: RTL and testbench

- Round-robin arbiter that shares one AXI slave write port (AW/W/B) between NUM_M master write ports.
- Sits between the master-side agents/DUT masters and a single slave port (the slave interface on the bench side).
- Single outstanding write transaction: once granted, a master owns AW, W and B until its write response completes.
- Counts W beats against awlen and flags wlast mismatches.

---
 rtl/axi_arb_pkg.sv | 31 +++
 rtl/rr_arbiter.sv | 56 +++++
 rtl/axi_wr_arbiter.sv | 176 +++++++++++++++++
 tb/tb_axi_wr_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_arb_pkg.sv
// Shared definitions for the AXI write-channel arbiter.
//   - arb_state_e : arbiter FSM states
//   - aw_width()/w_width() : packed AW and W payload widths derived from the bus parameters
//   - AXI burst/response encodings and the awlen field position inside the AW payload
package axi_arb_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAddr = 2'd1,
        StData = 2'd2,
        StResp = 2'd3
    } arb_state_e;

    // AW payload is {awid, awaddr, awlen[7:0], awsize[2:0], awburst[1:0]}
    function automatic int unsigned aw_width(input int unsigned id_w, input int unsigned add_w);
        return id_w + add_w + 13;
    endfunction

    // W payload is {wdata, wstrb, wlast}
    function automatic int unsigned w_width(input int unsigned data_w);
        return data_w + data_w / 8 + 1;
    endfunction

    localparam int unsigned AWLEN_LSB = 5;
    localparam int unsigned AWLEN_W   = 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR  = 2'b01;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin request selector.
//   clk_i, rst_i : clock and asynchronous active-high reset
//   req_i        : request vector, one bit per master
//   upd_i        : strobe; moves the priority pointer to upd_idx_i + 1 (mod NUM_M)
//   upd_idx_i    : index of the master that just finished
//   gnt_o        : combinational one-hot winner (first request at or after the pointer)
module rr_arbiter #(
    parameter int unsigned NUM_M = 2,
    parameter int unsigned PTR_W = $clog2(NUM_M)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [NUM_M-1:0] req_i,
    input  logic             upd_i,
    input  logic [PTR_W-1:0] upd_idx_i,
    output logic [NUM_M-1:0] gnt_o
);

    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [PTR_W:0]   cand;
    logic             found;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (upd_i) begin
            rr_ptr_d = (upd_idx_i == PTR_W'(NUM_M - 1)) ? '0 : upd_idx_i + PTR_W'(1);
        end
    end

    // Scan NUM_M candidates starting at the pointer; one extra bit on cand lets the
    // modulo wrap work for non-power-of-two NUM_M.
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < NUM_M; i++) begin
            cand = {1'b0, rr_ptr_q} + (PTR_W + 1)'(i);
            if (cand >= (PTR_W + 1)'(NUM_M)) begin
                cand = cand - (PTR_W + 1)'(NUM_M);
            end
            if (!found && req_i[cand[PTR_W-1:0]]) begin
                gnt_o[cand[PTR_W-1:0]] = 1'b1;
                found                  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/axi_wr_arbiter.sv
// Round-robin arbiter sharing one AXI slave write port (AW/W/B) between NUM_M masters.
// One outstanding write: the granted master owns AW, W and B until its B handshake.
//   aclk, areset         : clock, asynchronous active-high reset
//   m_aw_pld/valid/ready : per-master AW channels (payload packed NUM_M wide)
//   m_w_pld/valid/ready  : per-master W channels
//   m_b_pld              : {bid,bresp} broadcast; m_bvalid/m_bready per master
//   s_*                  : the single slave-side AW/W/B channel
//   grant                : one-hot current owner, zero when idle
//   err_wlast            : one-cycle pulse after a beat whose wlast disagrees with awlen
module axi_wr_arbiter
    import axi_arb_pkg::*;
#(
    parameter int unsigned NUM_M      = 2,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADD_WIDTH  = 32,
    parameter int unsigned ID_WIDTH   = 8
) (
    input  logic                                             aclk,
    input  logic                                             areset,
    input  logic [NUM_M*aw_width(ID_WIDTH, ADD_WIDTH)-1:0]   m_aw_pld,
    input  logic [NUM_M-1:0]                                 m_awvalid,
    output logic [NUM_M-1:0]                                 m_awready,
    input  logic [NUM_M*w_width(DATA_WIDTH)-1:0]             m_w_pld,
    input  logic [NUM_M-1:0]                                 m_wvalid,
    output logic [NUM_M-1:0]                                 m_wready,
    output logic [ID_WIDTH+1:0]                              m_b_pld,
    output logic [NUM_M-1:0]                                 m_bvalid,
    input  logic [NUM_M-1:0]                                 m_bready,
    output logic [aw_width(ID_WIDTH, ADD_WIDTH)-1:0]         s_aw_pld,
    output logic                                             s_awvalid,
    input  logic                                             s_awready,
    output logic [w_width(DATA_WIDTH)-1:0]                   s_w_pld,
    output logic                                             s_wvalid,
    input  logic                                             s_wready,
    input  logic [ID_WIDTH+1:0]                              s_b_pld,
    input  logic                                             s_bvalid,
    output logic                                             s_bready,
    output logic [NUM_M-1:0]                                 grant,
    output logic                                             err_wlast
);

    localparam int unsigned AW_W  = aw_width(ID_WIDTH, ADD_WIDTH);
    localparam int unsigned W_W   = w_width(DATA_WIDTH);
    localparam int unsigned PTR_W = $clog2(NUM_M);

    arb_state_e           state_q, state_d;
    logic [NUM_M-1:0]     grant_q, grant_d;
    logic [AWLEN_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [AWLEN_W-1:0]   len_q, len_d;
    logic                 err_wlast_q, err_wlast_d;

    logic [NUM_M-1:0]     arb_gnt;
    logic                 rr_upd;
    logic [PTR_W-1:0]     g_idx;
    logic [AW_W-1:0]      sel_aw;
    logic [W_W-1:0]       sel_w;
    logic                 last_beat;

    rr_arbiter #(
        .NUM_M (NUM_M)
    ) u_rr_arbiter (
        .clk_i     (aclk),
        .rst_i     (areset),
        .req_i     (m_awvalid),
        .upd_i     (rr_upd),
        .upd_idx_i (g_idx),
        .gnt_o     (arb_gnt)
    );

    // Encode the registered one-hot grant for the payload muxes.
    always_comb begin
        g_idx = '0;
        for (int unsigned i = 0; i < NUM_M; i++) begin
            if (grant_q[i]) begin
                g_idx = PTR_W'(i);
            end
        end
    end

    assign sel_aw    = m_aw_pld[32'(g_idx) * AW_W +: AW_W];
    assign sel_w     = m_w_pld[32'(g_idx) * W_W +: W_W];
    assign last_beat = (beat_cnt_q == len_q);

    // State register
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            beat_cnt_q  <= '0;
            len_q       <= '0;
            err_wlast_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            beat_cnt_q  <= beat_cnt_d;
            len_q       <= len_d;
            err_wlast_q <= err_wlast_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        beat_cnt_d  = beat_cnt_q;
        len_d       = len_q;
        err_wlast_d = 1'b0;
        rr_upd      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (|m_awvalid) begin
                    grant_d = arb_gnt;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                if (s_awvalid && s_awready) begin
                    len_d      = sel_aw[AWLEN_LSB +: AWLEN_W];
                    beat_cnt_d = '0;
                    state_d    = StData;
                end
            end
            StData: begin
                if (s_wvalid && s_wready) begin
                    // Wraps to 0 on the 256th beat of an awlen=255 burst; unused afterwards.
                    beat_cnt_d  = beat_cnt_q + AWLEN_W'(1);
                    err_wlast_d = (sel_w[0] != last_beat);
                    // The beat count, not wlast, decides the end of the burst.
                    if (last_beat) begin
                        state_d = StResp;
                    end
                end
            end
            StResp: begin
                if (s_bvalid && s_bready) begin
                    rr_upd  = 1'b1;
                    grant_d = '0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output logic: everything forwarded combinationally through the grant mux.
    always_comb begin
        s_awvalid = 1'b0;
        m_awready = '0;
        s_wvalid  = 1'b0;
        m_wready  = '0;
        s_bready  = 1'b0;
        m_bvalid  = '0;
        unique case (state_q)
            StAddr: begin
                s_awvalid = m_awvalid[g_idx];
                m_awready = grant_q & {NUM_M{s_awready}};
            end
            StData: begin
                s_wvalid = m_wvalid[g_idx];
                m_wready = grant_q & {NUM_M{s_wready}};
            end
            StResp: begin
                s_bready = m_bready[g_idx];
                m_bvalid = grant_q & {NUM_M{s_bvalid}};
            end
            default: ;
        endcase
    end

    assign s_aw_pld  = sel_aw;
    assign s_w_pld   = sel_w;
    assign m_b_pld   = s_b_pld;
    assign grant     = grant_q;
    assign err_wlast = err_wlast_q;

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed bench for axi_wr_arbiter with two masters and a hand-driven slave.
module tb_axi_wr_arbiter;
    import axi_arb_pkg::*;

    localparam int unsigned NUM_M = 2;
    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 32;
    localparam int unsigned IW    = 8;
    localparam int unsigned AW_W  = aw_width(IW, AW);
    localparam int unsigned W_W   = w_width(DW);

    logic                    aclk = 1'b0;
    logic                    areset;
    logic [AW_W-1:0]         aw_tb [NUM_M];
    logic [W_W-1:0]          w_tb  [NUM_M];
    logic [NUM_M*AW_W-1:0]   m_aw_pld;
    logic [NUM_M-1:0]        m_awvalid, m_awready;
    logic [NUM_M*W_W-1:0]    m_w_pld;
    logic [NUM_M-1:0]        m_wvalid, m_wready;
    logic [IW+1:0]           m_b_pld;
    logic [NUM_M-1:0]        m_bvalid, m_bready;
    logic [AW_W-1:0]         s_aw_pld;
    logic                    s_awvalid, s_awready;
    logic [W_W-1:0]          s_w_pld;
    logic                    s_wvalid, s_wready;
    logic [IW+1:0]           s_b_pld;
    logic                    s_bvalid, s_bready;
    logic [NUM_M-1:0]        grant;
    logic                    err_wlast;

    int n_vec = 0;
    int n_err = 0;

    always #5 aclk = ~aclk;

    always_comb begin
        for (int i = 0; i < NUM_M; i++) begin
            m_aw_pld[i*AW_W +: AW_W] = aw_tb[i];
            m_w_pld[i*W_W +: W_W]    = w_tb[i];
        end
    end

    axi_wr_arbiter #(
        .NUM_M      (NUM_M),
        .DATA_WIDTH (DW),
        .ADD_WIDTH  (AW),
        .ID_WIDTH   (IW)
    ) dut (
        .aclk      (aclk),
        .areset    (areset),
        .m_aw_pld  (m_aw_pld),
        .m_awvalid (m_awvalid),
        .m_awready (m_awready),
        .m_w_pld   (m_w_pld),
        .m_wvalid  (m_wvalid),
        .m_wready  (m_wready),
        .m_b_pld   (m_b_pld),
        .m_bvalid  (m_bvalid),
        .m_bready  (m_bready),
        .s_aw_pld  (s_aw_pld),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_w_pld   (s_w_pld),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_b_pld   (s_b_pld),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready),
        .grant     (grant),
        .err_wlast (err_wlast)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [NUM_M-1:0] onehot(input int m);
        logic [NUM_M-1:0] v;
        v    = '0;
        v[m] = 1'b1;
        return v;
    endfunction

    function automatic logic [AW_W-1:0] mk_aw(input int m, input logic [31:0] addr,
                                              input logic [7:0] len);
        return {8'(32'h10 + m), addr, len, 3'd2, BURST_INCR};
    endfunction

    // bad=1 puts wlast on the first beat only, otherwise wlast marks the awlen-th beat.
    function automatic logic [W_W-1:0] wbeat(input int m, input int k, input logic [7:0] len,
                                             input bit bad);
        logic last;
        last = bad ? (k == 0) : (k == int'(len));
        return {32'hD000_0000 | (32'(m) << 16) | 32'(k), 4'hF, last};
    endfunction

    task automatic idle_inputs();
        m_awvalid = '0;
        m_wvalid  = '0;
        m_bready  = '0;
        s_awready = 1'b0;
        s_wready  = 1'b0;
        s_bvalid  = 1'b0;
        s_b_pld   = '0;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge aclk);
        #1;
        areset = 1'b0;
    endtask

    // One complete write by master m, which must be the arbitration winner. Called in IDLE at
    // 1 time unit after a rising edge; returns in IDLE at the same phase.
    task automatic serve(input int m, input logic [7:0] len, input logic [31:0] addr,
                         input bit toggle, input bit bad_last, input logic [1:0] resp,
                         input int exp_err);
        logic [NUM_M-1:0] oh;
        logic [AW_W-1:0]  aw;
        logic [IW+1:0]    bexp;
        int               beats;
        int               cyc;
        int               errs;
        bit               hs;
        oh           = onehot(m);
        aw           = mk_aw(m, addr, len);
        aw_tb[m]     = aw;
        m_awvalid[m] = 1'b1;
        #1;
        check_eq("idle_grant", 64'(grant), 64'(0));
        check_eq("idle_s_awvalid", 64'(s_awvalid), 64'(0));
        check_eq("idle_m_awready", 64'(m_awready), 64'(0));
        @(posedge aclk); #1;
        // Early W beat during ADDR must not be taken.
        m_wvalid[m] = 1'b1;
        w_tb[m]     = wbeat(m, 0, len, bad_last);
        s_wready    = 1'b1;
        #1;
        check_eq("addr_grant", 64'(grant), 64'(oh));
        check_eq("addr_s_awvalid", 64'(s_awvalid), 64'(1));
        check_eq("addr_s_aw_pld", 64'(s_aw_pld), 64'(aw));
        check_eq("addr_m_wready", 64'(m_wready), 64'(0));
        check_eq("addr_s_wvalid", 64'(s_wvalid), 64'(0));
        s_awready = 1'b1;
        #1;
        check_eq("addr_m_awready", 64'(m_awready), 64'(oh));
        @(posedge aclk); #1;
        m_awvalid[m] = 1'b0;
        s_awready    = 1'b0;
        beats = 0;
        cyc   = 0;
        errs  = 0;
        while (beats <= int'(len) && cyc < 1000) begin
            s_wready = toggle ? (cyc % 2 == 0) : 1'b1;
            w_tb[m]  = wbeat(m, beats, len, bad_last);
            #1;
            check_eq("data_m_wready", 64'(m_wready), 64'(s_wready ? oh : '0));
            hs = s_wvalid && s_wready;
            if (hs) begin
                check_eq("data_s_w_pld", 64'(s_w_pld), 64'(wbeat(m, beats, len, bad_last)));
            end
            if (err_wlast) errs++;
            @(posedge aclk); #1;
            if (hs) beats++;
            cyc++;
        end
        check_eq("beats_accepted", 64'(beats), 64'(int'(len) + 1));
        // Now in RESP: W must be closed even though the master still offers a beat.
        s_wready = 1'b1;
        #1;
        if (err_wlast) errs++;
        check_eq("resp_m_wready", 64'(m_wready), 64'(0));
        check_eq("resp_s_wvalid", 64'(s_wvalid), 64'(0));
        check_eq("err_wlast_pulses", 64'(errs), 64'(exp_err));
        m_wvalid[m] = 1'b0;
        bexp     = {8'(32'hB0 + m), resp};
        s_bvalid = 1'b1;
        s_b_pld  = bexp;
        #1;
        check_eq("resp_m_bvalid", 64'(m_bvalid), 64'(oh));
        check_eq("resp_m_b_pld", 64'(m_b_pld), 64'(bexp));
        check_eq("resp_s_bready_lo", 64'(s_bready), 64'(0));
        m_bready[m] = 1'b1;
        #1;
        check_eq("resp_s_bready_hi", 64'(s_bready), 64'(1));
        @(posedge aclk); #1;
        s_bvalid    = 1'b0;
        m_bready[m] = 1'b0;
        s_wready    = 1'b0;
        #1;
        check_eq("done_grant", 64'(grant), 64'(0));
        check_eq("done_m_bvalid", 64'(m_bvalid), 64'(0));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NUM_M; i++) begin
            aw_tb[i] = '0;
            w_tb[i]  = '0;
        end
        // Reset with every input active: all outputs must stay quiet.
        areset    = 1'b1;
        m_awvalid = '1;
        m_wvalid  = '1;
        m_bready  = '1;
        s_awready = 1'b1;
        s_wready  = 1'b1;
        s_bvalid  = 1'b1;
        s_b_pld   = '0;
        @(posedge aclk); #1;
        check_eq("rst_grant", 64'(grant), 64'(0));
        check_eq("rst_s_awvalid", 64'(s_awvalid), 64'(0));
        check_eq("rst_m_awready", 64'(m_awready), 64'(0));
        check_eq("rst_m_wready", 64'(m_wready), 64'(0));
        check_eq("rst_m_bvalid", 64'(m_bvalid), 64'(0));
        check_eq("rst_s_bready", 64'(s_bready), 64'(0));
        check_eq("rst_err_wlast", 64'(err_wlast), 64'(0));
        do_reset();

        // Single master, 4 beats.
        serve(0, 8'd3, 32'h1000, 1'b0, 1'b0, RESP_OKAY, 0);

        // Contention from reset: M0, M1, M0, M1.
        do_reset();
        aw_tb[1]  = mk_aw(1, 32'h2000, 8'd0);
        m_awvalid = 2'b11;
        serve(0, 8'd1, 32'h2100, 1'b0, 1'b0, RESP_OKAY, 0);
        m_awvalid[0] = 1'b1;
        serve(1, 8'd0, 32'h2200, 1'b0, 1'b0, RESP_OKAY, 0);
        m_awvalid[1] = 1'b1;
        serve(0, 8'd2, 32'h2300, 1'b0, 1'b0, RESP_OKAY, 0);
        serve(1, 8'd0, 32'h2400, 1'b0, 1'b0, RESP_OKAY, 0);

        // Backpressure on W while M1 offers beats it must never get accepted.
        m_wvalid[1] = 1'b1;
        w_tb[1]     = wbeat(1, 0, 8'd0, 1'b0);
        serve(0, 8'd7, 32'h3000, 1'b1, 1'b0, RESP_OKAY, 0);
        m_wvalid[1] = 1'b0;

        // Maximum burst length.
        serve(1, 8'd255, 32'h4000, 1'b0, 1'b0, RESP_OKAY, 0);

        // Misplaced wlast: two error pulses, burst still ends on the length.
        serve(0, 8'd1, 32'h5000, 1'b0, 1'b1, RESP_SLVERR, 2);

        // Reset mid-burst after 2 of 4 beats. rr_ptr is 1 here, reset must return it to 0.
        aw_tb[0]     = mk_aw(0, 32'h6000, 8'd3);
        m_awvalid[0] = 1'b1;
        @(posedge aclk); #1;
        s_awready = 1'b1;
        @(posedge aclk); #1;
        m_awvalid[0] = 1'b0;
        s_awready    = 1'b0;
        m_wvalid[0]  = 1'b1;
        s_wready     = 1'b1;
        w_tb[0]      = wbeat(0, 0, 8'd3, 1'b0);
        @(posedge aclk); #1;
        w_tb[0] = wbeat(0, 1, 8'd3, 1'b0);
        @(posedge aclk); #1;
        check_eq("mid_grant", 64'(grant), 64'(2'b01));
        check_eq("mid_m_wready", 64'(m_wready), 64'(2'b01));
        areset = 1'b1;
        #1;
        check_eq("arst_grant", 64'(grant), 64'(0));
        check_eq("arst_s_wvalid", 64'(s_wvalid), 64'(0));
        check_eq("arst_m_wready", 64'(m_wready), 64'(0));
        check_eq("arst_s_awvalid", 64'(s_awvalid), 64'(0));
        check_eq("arst_m_bvalid", 64'(m_bvalid), 64'(0));
        check_eq("arst_s_bready", 64'(s_bready), 64'(0));
        check_eq("arst_err_wlast", 64'(err_wlast), 64'(0));
        idle_inputs();
        @(posedge aclk); #1;
        areset    = 1'b0;
        aw_tb[1]  = mk_aw(1, 32'h7000, 8'd1);
        m_awvalid = 2'b11;
        serve(0, 8'd0, 32'h7100, 1'b0, 1'b0, RESP_OKAY, 0);
        serve(1, 8'd1, 32'h7200, 1'b0, 1'b0, RESP_OKAY, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
